pipe_ctrl: RTL and testbench

Parametrised pipeline controller for the in-order MIPS core, replacing the fixed 6-bit stall generator. Arbitrates per-stage stall requests and one flush/redirect request into hold, bubble and kill vectors for an N-stage pipeline. Tracks per-stage occupancy so requests from empty stages are ignored, and keeps stall, flush and retire performance counters. Sits beside the stage modules in the core top; every pipeline register consumes its bit of `stall`, `bubble` and `flush`.

---
 rtl/pipe_pkg.sv | 17 +
 rtl/pipe_ctrl_if.sv | 26 ++
 rtl/perf_counter.sv | 18 +
 rtl/pipe_ctrl.sv | 111 +++++++++++
 tb/tb_pipe_ctrl.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared defaults and named stage indices for the in-order MIPS pipeline controller.
package pipe_pkg;

   localparam int DEF_NUM_STAGES  = 5;
   localparam int DEF_FLUSH_STAGE = 3;
   localparam int DEF_PC_W        = 32;
   localparam int DEF_CNT_W       = 32;

   typedef enum int {
      STAGE_IF  = 0,
      STAGE_ID  = 1,
      STAGE_EX  = 2,
      STAGE_MEM = 3,
      STAGE_WB  = 4
   } stage_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/control bundle between the pipeline stages and pipe_ctrl.
interface pipe_ctrl_if import pipe_pkg::*; #(
   parameter int NUM_STAGES = DEF_NUM_STAGES,
   parameter int PC_W       = DEF_PC_W
) ();

   logic [NUM_STAGES-1:0] stallreq;
   logic                  flushreq;
   logic [PC_W-1:0]       flush_pc;
   logic [NUM_STAGES-1:0] stall;
   logic [NUM_STAGES-1:0] bubble;
   logic [NUM_STAGES-1:0] flush;
   logic                  pc_load;
   logic [PC_W-1:0]       pc_target;

   modport master (
      output stallreq, flushreq, flush_pc,
      input  stall, bubble, flush, pc_load, pc_target
   );

   modport slave (
      input  stallreq, flushreq, flush_pc,
      output stall, bubble, flush, pc_load, pc_target
   );

endinterface

// File: rtl/perf_counter.sv
// Wrap-around event counter with increment enable and asynchronous active-low clear.
module perf_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         count <= '0;
      else if (inc)
         count <= count + CNT_W'(1);
   end

endmodule

// File: rtl/pipe_ctrl.sv
// N-stage pipeline controller: masks stall requests by occupancy, priority-encodes the
// oldest stalling stage into hold/bubble vectors, arbitrates the flush and tracks occupancy.
module pipe_ctrl import pipe_pkg::*; #(
   parameter int NUM_STAGES  = DEF_NUM_STAGES,
   parameter int FLUSH_STAGE = DEF_FLUSH_STAGE,
   parameter int PC_W        = DEF_PC_W,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic                  clk,
   input  logic                  rst,
   pipe_ctrl_if.slave            bus,
   output logic [NUM_STAGES-1:0] stage_valid,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      flush_cnt,
   output logic [CNT_W-1:0]      retire_cnt
);

   logic [NUM_STAGES-1:0] v;
   logic [NUM_STAGES-1:0] v_next;
   logic [NUM_STAGES-1:0] req;
   logic [NUM_STAGES-1:0] stall_c;
   logic [NUM_STAGES-1:0] bubble_c;
   logic [NUM_STAGES-1:0] flush_c;
   logic [PC_W-1:0]       target;
   logic                  older_req;
   logic                  flush_taken;
   int                    top;

   assign req         = bus.stallreq & v;
   assign older_req   = |req[NUM_STAGES-1:FLUSH_STAGE+1];
   assign flush_taken = bus.flushreq & v[FLUSH_STAGE] & ~older_req;

   // The oldest requesting stage holds itself and everything younger; the stage after it
   // receives a bubble. A taken flush overrides stall/bubble over the region it kills.
   always_comb begin
      top      = -1;
      stall_c  = '0;
      bubble_c = '0;
      flush_c  = '0;
      for (int s = 0; s < NUM_STAGES; s++)
         if (req[s]) top = s;
      for (int s = 0; s < NUM_STAGES; s++) begin
         stall_c[s]  = (s <= top);
         bubble_c[s] = (top >= 0) && (s == top + 1);
      end
      if (flush_taken) begin
         for (int s = 0; s <= FLUSH_STAGE + 1; s++) begin
            stall_c[s]  = 1'b0;
            bubble_c[s] = 1'b0;
            flush_c[s]  = (s >= 1);
         end
      end
   end

   // Occupancy follows the instructions: held stages keep theirs, bubbles empty a stage,
   // everything else inherits from the stage behind; IF always refills unless held.
   always_comb begin
      v_next    = v;
      v_next[0] = stall_c[0] ? v[0] : 1'b1;
      for (int s = 1; s < NUM_STAGES; s++) begin
         if (stall_c[s])
            v_next[s] = v[s];
         else if (bubble_c[s])
            v_next[s] = 1'b0;
         else
            v_next[s] = v[s-1];
      end
      if (flush_taken) begin
         v_next[0] = 1'b1;
         for (int s = 1; s <= FLUSH_STAGE + 1; s++)
            v_next[s] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         v <= '0;
      else
         v <= v_next;
   end

   assign target        = bus.flush_pc;
   assign bus.pc_target = target;
   assign bus.stall     = stall_c;
   assign bus.bubble    = bubble_c;
   assign bus.flush     = flush_c;
   assign bus.pc_load   = flush_taken;
   assign stage_valid   = v;

   perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (|req),
      .count (stall_cnt)
   );

   perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (flush_taken),
      .count (flush_cnt)
   );

   perf_counter #(.CNT_W(CNT_W)) u_retire_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (v[NUM_STAGES-1] & ~stall_c[NUM_STAGES-1]),
      .count (retire_cnt)
   );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed vector table, counter wrap/reset sequence,
// then randomized requests against a behavioural reference model.
module tb_pipe_ctrl;

   localparam int N  = 5;
   localparam int F  = 3;
   localparam int PW = 32;
   localparam int CW = 4;
   localparam logic [PW-1:0] EXC_PC = 32'hBFC00380;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   pipe_ctrl_if #(.NUM_STAGES(N), .PC_W(PW)) bus ();

   logic [N-1:0]  stage_valid;
   logic [CW-1:0] stall_cnt;
   logic [CW-1:0] flush_cnt;
   logic [CW-1:0] retire_cnt;

   pipe_ctrl #(.NUM_STAGES(N), .FLUSH_STAGE(F), .PC_W(PW), .CNT_W(CW)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .stage_valid (stage_valid),
      .stall_cnt   (stall_cnt),
      .flush_cnt   (flush_cnt),
      .retire_cnt  (retire_cnt)
   );

   typedef struct {
      logic [N-1:0] sreq;
      logic         freq;
      logic [N-1:0] e_stall;
      logic [N-1:0] e_bubble;
      logic [N-1:0] e_flush;
      logic         e_pcl;
      logic [N-1:0] e_v;
      int           e_sc;
      int           e_fc;
      int           e_rc;
   } vec_t;

   vec_t tbl[$];
   int   compared   = 0;
   int   mismatched = 0;

   function automatic vec_t mk(logic [N-1:0] sreq, logic freq, logic [N-1:0] st,
                               logic [N-1:0] bb, logic [N-1:0] fl, logic pcl,
                               logic [N-1:0] v, int sc, int fc, int rc);
      vec_t r;
      r.sreq = sreq; r.freq = freq; r.e_stall = st; r.e_bubble = bb; r.e_flush = fl;
      r.e_pcl = pcl; r.e_v = v; r.e_sc = sc; r.e_fc = fc; r.e_rc = rc;
      return r;
   endfunction

   task automatic applyStimulus(input logic [N-1:0] sreq, input logic freq, input logic [PW-1:0] pc);
      @(negedge clk);
      bus.stallreq = sreq;
      bus.flushreq = freq;
      bus.flush_pc = pc;
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkZeroState(input string tag);
      checkOutput({tag, " stage_valid"}, 32'(stage_valid), 0);
      checkOutput({tag, " stall_cnt"},   32'(stall_cnt), 0);
      checkOutput({tag, " flush_cnt"},   32'(flush_cnt), 0);
      checkOutput({tag, " retire_cnt"},  32'(retire_cnt), 0);
      checkOutput({tag, " stall"},       32'(bus.stall), 0);
      checkOutput({tag, " bubble"},      32'(bus.bubble), 0);
      checkOutput({tag, " flush"},       32'(bus.flush), 0);
      checkOutput({tag, " pc_load"},     32'(bus.pc_load), 0);
   endtask

   // Reference model state
   logic [N-1:0] vm;
   int           sm, fm, rm;

   initial begin
      logic [N-1:0]  sreq;
      logic          freq;
      logic [PW-1:0] pc;
      logic [N-1:0]  req;
      logic [N-1:0]  vn;
      int            k, es, eb, ef, lowmask;
      bit            taken;

      bus.stallreq = '1;
      bus.flushreq = 1'b1;
      bus.flush_pc = EXC_PC;
      #2;
      checkZeroState("reset");
      @(posedge clk);
      #1 rst = 1'b1;

      // Fill, EX stall, flush, masked request, refill, WB-deferred flush, flush beating EX stall
      tbl.push_back(mk(5'b00000, 0, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00001, 0, 0, 0));
      tbl.push_back(mk(5'b00000, 0, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00011, 0, 0, 0));
      tbl.push_back(mk(5'b00000, 0, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00111, 0, 0, 0));
      tbl.push_back(mk(5'b00000, 0, 5'b00000, 5'b00000, 5'b00000, 0, 5'b01111, 0, 0, 0));
      tbl.push_back(mk(5'b00000, 0, 5'b00000, 5'b00000, 5'b00000, 0, 5'b11111, 0, 0, 0));
      tbl.push_back(mk(5'b00000, 0, 5'b00000, 5'b00000, 5'b00000, 0, 5'b11111, 0, 0, 1));
      tbl.push_back(mk(5'b00100, 0, 5'b00111, 5'b01000, 5'b00000, 0, 5'b10111, 1, 0, 2));
      tbl.push_back(mk(5'b00100, 0, 5'b00111, 5'b01000, 5'b00000, 0, 5'b00111, 2, 0, 3));
      tbl.push_back(mk(5'b00100, 0, 5'b00111, 5'b01000, 5'b00000, 0, 5'b00111, 3, 0, 3));
      tbl.push_back(mk(5'b00000, 0, 5'b00000, 5'b00000, 5'b00000, 0, 5'b01111, 3, 0, 3));
      tbl.push_back(mk(5'b00000, 0, 5'b00000, 5'b00000, 5'b00000, 0, 5'b11111, 3, 0, 3));
      tbl.push_back(mk(5'b00000, 1, 5'b00000, 5'b00000, 5'b11110, 1, 5'b00001, 3, 1, 4));
      tbl.push_back(mk(5'b00010, 0, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00011, 3, 1, 4));
      tbl.push_back(mk(5'b00000, 0, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00111, 3, 1, 4));
      tbl.push_back(mk(5'b00000, 0, 5'b00000, 5'b00000, 5'b00000, 0, 5'b01111, 3, 1, 4));
      tbl.push_back(mk(5'b00000, 0, 5'b00000, 5'b00000, 5'b00000, 0, 5'b11111, 3, 1, 4));
      tbl.push_back(mk(5'b10000, 1, 5'b11111, 5'b00000, 5'b00000, 0, 5'b11111, 4, 1, 4));
      tbl.push_back(mk(5'b00000, 1, 5'b00000, 5'b00000, 5'b11110, 1, 5'b00001, 4, 2, 5));
      tbl.push_back(mk(5'b00000, 1, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00011, 4, 2, 5));
      tbl.push_back(mk(5'b00000, 0, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00111, 4, 2, 5));
      tbl.push_back(mk(5'b00000, 0, 5'b00000, 5'b00000, 5'b00000, 0, 5'b01111, 4, 2, 5));
      tbl.push_back(mk(5'b00100, 1, 5'b00000, 5'b00000, 5'b11110, 1, 5'b00001, 5, 3, 5));

      foreach (tbl[i]) begin
         applyStimulus(tbl[i].sreq, tbl[i].freq, EXC_PC);
         checkOutput($sformatf("vec%0d stall", i),     32'(bus.stall),     32'(tbl[i].e_stall));
         checkOutput($sformatf("vec%0d bubble", i),    32'(bus.bubble),    32'(tbl[i].e_bubble));
         checkOutput($sformatf("vec%0d flush", i),     32'(bus.flush),     32'(tbl[i].e_flush));
         checkOutput($sformatf("vec%0d pc_load", i),   32'(bus.pc_load),   32'(tbl[i].e_pcl));
         checkOutput($sformatf("vec%0d pc_target", i), bus.pc_target,      EXC_PC);
         @(posedge clk);
         #1;
         checkOutput($sformatf("vec%0d valid", i),     32'(stage_valid),   32'(tbl[i].e_v));
         checkOutput($sformatf("vec%0d stall_cnt", i), 32'(stall_cnt),     tbl[i].e_sc);
         checkOutput($sformatf("vec%0d flush_cnt", i), 32'(flush_cnt),     tbl[i].e_fc);
         checkOutput($sformatf("vec%0d retire", i),    32'(retire_cnt),    tbl[i].e_rc);
      end

      // Mid-operation reset clears state and outputs without waiting for an edge
      bus.stallreq = 5'b00100;
      bus.flushreq = 1'b0;
      #2 rst = 1'b0;
      #1;
      checkZeroState("midreset");

      // Counter wrap: refill, then 16 EX-stall cycles take stall_cnt 15 -> 0
      @(posedge clk);
      #1 rst = 1'b1;
      for (int i = 0; i < N; i++) begin
         applyStimulus('0, 1'b0, EXC_PC);
         @(posedge clk);
      end
      #1 checkOutput("wrap prefill valid", 32'(stage_valid), 32'h1F);
      for (int i = 1; i <= 18; i++) begin
         applyStimulus(5'b00100, 1'b0, EXC_PC);
         @(posedge clk);
         #1;
         checkOutput($sformatf("wrap stall_cnt %0d", i), 32'(stall_cnt), i % 16);
      end
      #2 rst = 1'b0;
      #1;
      checkZeroState("wrapreset");

      // Randomized phase against the reference model
      @(posedge clk);
      #1 rst = 1'b1;
      vm = '0; sm = 0; fm = 0; rm = 0;
      freq = 1'b0;
      pc = '0;
      taken = 1'b0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         sreq = '0;
         for (int s = 0; s < N; s++)
            if ($urandom_range(0, 5) == 0) sreq[s] = 1'b1;
         if (!(freq && !taken)) begin
            freq = ($urandom_range(0, 4) == 0);
            pc   = $urandom;
         end
         applyStimulus(sreq, freq, pc);

         req = sreq & vm;
         k = -1;
         for (int s = 0; s < N; s++)
            if (req[s]) k = s;
         es = (k >= 0) ? ((1 << (k + 1)) - 1) : 0;
         eb = (k >= 0 && k < N - 1) ? (1 << (k + 1)) : 0;
         taken = freq && vm[F] && ((int'(req) >> (F + 1)) == 0);
         lowmask = (1 << (F + 2)) - 1;
         ef = 0;
         if (taken) begin
            es = es & ~lowmask;
            eb = eb & ~lowmask;
            ef = lowmask & ~1;
         end
         checkOutput("rnd stall",     32'(bus.stall),   es);
         checkOutput("rnd bubble",    32'(bus.bubble),  eb);
         checkOutput("rnd flush",     32'(bus.flush),   ef);
         checkOutput("rnd pc_load",   32'(bus.pc_load), 32'(taken));
         checkOutput("rnd pc_target", bus.pc_target,    pc);

         for (int s = 0; s < N; s++) begin
            if (taken && s <= F + 1)
               vn[s] = (s == 0);
            else if ((es >> s) & 1)
               vn[s] = vm[s];
            else if ((eb >> s) & 1)
               vn[s] = 1'b0;
            else
               vn[s] = (s == 0) ? 1'b1 : vm[s-1];
         end
         sm = (sm + ((req != 0) ? 1 : 0)) % 16;
         fm = (fm + (taken ? 1 : 0)) % 16;
         rm = (rm + ((vm[N-1] && !((es >> (N - 1)) & 1)) ? 1 : 0)) % 16;
         vm = vn;

         @(posedge clk);
         #1;
         checkOutput("rnd valid",     32'(stage_valid), 32'(vm));
         checkOutput("rnd stall_cnt", 32'(stall_cnt),   sm);
         checkOutput("rnd flush_cnt", 32'(flush_cnt),   fm);
         checkOutput("rnd retire",    32'(retire_cnt),  rm);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
